// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - memory-bus responder serving word/byte requests from an async 16-bit SRAM
module sram_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              write_enable,
    input  logic              byte_enable,
    input  logic              byte_select,
    input  logic [15:0]       addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              mem_wait,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_we_q, req_we_d;
    logic              req_be_q, req_be_d;
    logic              req_sel_q, req_sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic [15:0]       dout_q, dout_d;
    logic              dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              strobe_on;
    logic [15:0]       rd_lane;

    // Byte reads are zero-extended from the lane named by the latched request.
    always_comb begin
        rd_lane = sram_dq_in;
        if (req_be_q) begin
            rd_lane = {8'h00, req_sel_q ? sram_dq_in[15:8] : sram_dq_in[7:0]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_we_d  = req_we_q;
        req_be_d  = req_be_q;
        req_sel_d = req_sel_q;
        addr_d    = addr_q;
        dq_out_d  = dq_out_q;
        dout_d    = dout_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = SETUP;
                    req_we_d  = write_enable;
                    req_be_d  = byte_enable;
                    req_sel_d = byte_select;
                    addr_d    = addr[ADDR_W-1:0];
                    if (write_enable) begin
                        dq_out_d = byte_enable ? {data_in[7:0], data_in[7:0]} : data_in;
                    end
                end
            end
            SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (!req_we_q) begin
                        dout_d = rd_lane;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so the SRAM pins never glitch.
    always_comb begin
        strobe_on = (state_d == SETUP) || (state_d == ACCESS);
        ce_n_d    = !strobe_on;
        ub_n_d    = !(strobe_on && (!req_be_d || req_sel_d));
        lb_n_d    = !(strobe_on && (!req_be_d || !req_sel_d));
        oe_n_d    = !((state_d == ACCESS) && !req_we_d);
        we_n_d    = !((state_d == ACCESS) && req_we_d);
        dq_oe_d   = req_we_d && (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_we_q  <= 1'b0;
            req_be_q  <= 1'b0;
            req_sel_q <= 1'b0;
            addr_q    <= '0;
            dq_out_q  <= 16'h0000;
            dout_q    <= 16'h0000;
            dq_oe_q   <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_we_q  <= req_we_d;
            req_be_q  <= req_be_d;
            req_sel_q <= req_sel_d;
            addr_q    <= addr_d;
            dq_out_q  <= dq_out_d;
            dout_q    <= dout_d;
            dq_oe_q   <= dq_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
        end
    end

    assign mem_wait    = ((state_q == IDLE) && en) || (state_q == SETUP) || (state_q == ACCESS);
    assign data_out    = dout_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = we_n_q;
    assign sram_ub_n   = ub_n_q;
    assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - scoreboard bench for sram_responder (WS=2/ADDR_W=16 and WS=1/ADDR_W=8)
module tb_sram_responder;
    localparam int WS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, we, be, sel;
    logic [15:0] addr, din, dout, sram_addr, dq_out, dq_in;
    logic        mw, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;

    logic        en_b, we_b, be_b, sel_b;
    logic [15:0] addr_b, din_b, dout_b, dq_out_b, dq_in_b;
    logic [7:0]  sram_addr_b;
    logic        mw_b, dq_oe_b, ce_n_b, oe_n_b, we_n_b, ub_n_b, lb_n_b;

    sram_responder #(.ADDR_W(16), .WAIT_STATES(WS)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .write_enable(we), .byte_enable(be),
        .byte_select(sel), .addr(addr), .data_in(din), .data_out(dout), .mem_wait(mw),
        .sram_addr(sram_addr), .sram_dq_out(dq_out), .sram_dq_oe(dq_oe), .sram_dq_in(dq_in),
        .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
    );

    sram_responder #(.ADDR_W(8), .WAIT_STATES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .write_enable(we_b), .byte_enable(be_b),
        .byte_select(sel_b), .addr(addr_b), .data_in(din_b), .data_out(dout_b), .mem_wait(mw_b),
        .sram_addr(sram_addr_b), .sram_dq_out(dq_out_b), .sram_dq_oe(dq_oe_b), .sram_dq_in(dq_in_b),
        .sram_ce_n(ce_n_b), .sram_oe_n(oe_n_b), .sram_we_n(we_n_b), .sram_ub_n(ub_n_b), .sram_lb_n(lb_n_b)
    );

    // Async SRAM model for instance A; instance B reads a fixed address-derived pattern.
    logic [15:0] mem [256];
    always @(posedge clk) begin
        if (!ce_n && !we_n && dq_oe) begin
            if (!ub_n) mem[sram_addr[7:0]][15:8] <= dq_out[15:8];
            if (!lb_n) mem[sram_addr[7:0]][7:0]  <= dq_out[7:0];
        end
    end
    assign dq_in   = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
    assign dq_in_b = (!ce_n_b && !oe_n_b) ? (16'hC0DE ^ {8'h00, sram_addr_b}) : 16'h0000;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=expired required=event", name);
    endtask

    typedef struct {
        logic        we, be, sel, b2b, abort;
        logic [15:0] addr, dq, data;
    } exp_t;
    typedef struct {
        logic [7:0]  addr;
        logic [15:0] data;
    } expb_t;

    exp_t  q[$];
    expb_t qb[$];
    logic  mon_en = 1'b0;
    int    cyc_cnt = 0;
    bit    active = 0, active_b = 0;

    initial forever begin
        @(posedge clk);
        cyc_cnt++;
    end

    // Monitor A: pops an expectation at each acceptance, checks pins every cycle, result at DONE.
    initial begin
        logic prev_mw;
        int   cyc, last_rise;
        exp_t cur;
        logic sa, ac, e_dq_oe;
        logic [15:0] e_pins;
        prev_mw = 1'b0;
        cyc = 0;
        last_rise = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!prev_mw && mw) begin
                    if (q.size() == 0) begin
                        fail("unexpected_accept");
                    end else begin
                        cur = q.pop_front();
                        active = 1;
                        cyc = 0;
                        if (cur.b2b) chk("b2b_interval", 16'(cyc_cnt - last_rise), 16'(WS + 3));
                    end
                    last_rise = cyc_cnt;
                end else if (active) begin
                    cyc++;
                end
                if (active) begin
                    sa = (cyc >= 1) && (cyc <= WS + 1);
                    ac = (cyc >= 2) && (cyc <= WS + 1);
                    e_dq_oe = cur.we && (cyc >= 1) && (cyc <= WS + 2) && !(cur.abort && cyc == WS + 2);
                    e_pins = {10'd0, !sa, !(sa && (!cur.be || cur.sel)), !(sa && (!cur.be || !cur.sel)),
                              !(ac && cur.we), !(ac && !cur.we), e_dq_oe};
                    chk("pins", {10'd0, ce_n, ub_n, lb_n, we_n, oe_n, dq_oe}, e_pins);
                    if (cyc >= 1 && cyc <= WS + 2 && !(cur.abort && cyc == WS + 2))
                        chk("sram_addr", sram_addr, cur.addr);
                    if (e_dq_oe) chk("sram_dq_out", dq_out, cur.dq);
                    if (!mw) begin
                        chk("done_cycle", 16'(cyc), 16'(WS + 2));
                        chk("data_out", dout, cur.data);
                        active = 0;
                    end else if (cyc > WS + 5) begin
                        fail("access_timeout");
                        active = 0;
                    end
                end else begin
                    chk("idle_pins", {10'd0, ce_n, ub_n, lb_n, we_n, oe_n, dq_oe}, 16'h003E);
                end
                prev_mw = mw;
            end
        end
    end

    // Monitor B: small-address, single-wait-state instance.
    initial begin
        logic  prev;
        int    cyc;
        expb_t cur;
        prev = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!prev && mw_b) begin
                    if (qb.size() == 0) fail("b_unexpected_accept");
                    else begin
                        cur = qb.pop_front();
                        active_b = 1;
                        cyc = 0;
                    end
                end else if (active_b) begin
                    cyc++;
                end
                if (active_b) begin
                    if (cyc == 1) chk("b_sram_addr", {8'h00, sram_addr_b}, {8'h00, cur.addr});
                    chk("b_oe_n", 16'(oe_n_b), 16'(cyc != 2));
                    if (!mw_b) begin
                        chk("b_done_cycle", 16'(cyc), 16'd3);
                        chk("b_data_out", dout_b, cur.data);
                        active_b = 0;
                    end else if (cyc > 8) begin
                        fail("b_access_timeout");
                        active_b = 0;
                    end
                end
                prev = mw_b;
            end
        end
    end

    task automatic wait_idle_a();
        int n = 0;
        while (mw && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail("idle_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic w, b, s, b2b, ab, input logic [15:0] a, d, ed);
        exp_t e;
        e.we = w; e.be = b; e.sel = s; e.b2b = b2b; e.abort = ab;
        e.addr = a;
        e.dq = b ? {d[7:0], d[7:0]} : d;
        e.data = ed;
        q.push_back(e);
        we = w; be = b; sel = s; addr = a; din = d;
    endtask

    // One request; inputs are scrambled right after acceptance.
    task automatic issue(input logic w, b, s, input logic [15:0] a, d, ed, input logic ab);
        wait_idle_a();
        push_a(w, b, s, 1'b0, ab, a, d, ed);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; we = ~w; be = ~b; sel = ~s; addr = ~a; din = ~d;
    endtask

    task automatic issue_b(input logic b, s, input logic [15:0] a, input logic [7:0] ea, input logic [15:0] ed);
        expb_t e;
        int n = 0;
        while (mw_b && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) fail("b_idle_wait");
        @(posedge clk);
        #1;
        e.addr = ea;
        e.data = ed;
        qb.push_back(e);
        en_b = 1'b1; we_b = 1'b0; be_b = b; sel_b = s; addr_b = a; din_b = 16'hFFFF;
        @(posedge clk);
        #1;
        en_b = 1'b0; addr_b = ~a; be_b = ~b; sel_b = ~s;
    endtask

    initial begin
        logic        bw [4];
        logic [15:0] ba [4];
        logic [15:0] bd [4];
        logic [15:0] be_exp [4];
        int          n;
        rst_n = 1'b0; en = 1'b0; we = 1'b0; be = 1'b0; sel = 1'b0; addr = 16'h0; din = 16'h0;
        en_b = 1'b0; we_b = 1'b0; be_b = 1'b0; sel_b = 1'b0; addr_b = 16'h0; din_b = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_out", dout, 16'h0000);
        chk("reset_sram_addr", sram_addr, 16'h0000);
        chk("reset_dq_out", dq_out, 16'h0000);
        chk("reset_pins", {10'd0, ce_n, ub_n, lb_n, we_n, oe_n, dq_oe}, 16'h003E);
        chk("reset_mem_wait", 16'(mw), 16'h0000);
        chk("reset_b_data_out", dout_b, 16'h0000);
        chk("reset_b_sram_addr", {8'h00, sram_addr_b}, 16'h0000);
        rst_n = 1'b1;
        mon_en = 1'b1;

        issue(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
        issue(1'b1, 1'b0, 1'b0, 16'h0020, 16'h5555, 16'hBEEF, 1'b0);
        issue(1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234, 16'hBEEF, 1'b0);
        issue(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h34EF, 1'b0);
        issue(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00EF, 1'b0);
        issue(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0034, 1'b0);

        // en held high across four requests alternating addresses 0 and 1.
        bw = '{1'b1, 1'b1, 1'b0, 1'b0};
        ba = '{16'h0000, 16'h0001, 16'h0000, 16'h0001};
        bd = '{16'hA1A1, 16'hB2B2, 16'h0000, 16'h0000};
        be_exp = '{16'h0034, 16'h0034, 16'hA1A1, 16'hB2B2};
        wait_idle_a();
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_a(bw[i], 1'b0, 1'b0, (i != 0), 1'b0, ba[i], bd[i], be_exp[i]);
            if (i == 0) begin
                @(posedge clk);
                #1;
            end else begin
                repeat (WS + 3) @(posedge clk);
                #1;
            end
        end
        en = 1'b0;

        // Reset in the second ACCESS cycle of a write.
        issue(1'b1, 1'b0, 1'b0, 16'h0030, 16'h7777, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);

        issue_b(1'b0, 1'b0, 16'h0105, 8'h05, 16'hC0DB);
        issue_b(1'b1, 1'b1, 16'h00FF, 8'hFF, 16'h00C0);

        n = 0;
        while ((q.size() != 0 || qb.size() != 0 || active || active_b) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) fail("drain");
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Responder end of the core's memory bus: accepts the core's word-addressed read/write requests and serves them from an external asynchronous 16-bit SRAM, which has upper/lower byte strobes.
- Generates mem_wait back to the core's control FSM.
- Handles byte-lane selection and zero-extends byte reads.
- Sits between the core's memory port and the board SRAM pins, and replaces the on-chip memory when a larger store is needed.

Parameters:
- ADDR_W, 16: SRAM word-address width. sram_addr = addr[ADDR_W-1:0]. Legal range 1..16.
- WAIT_STATES, 2: SRAM strobe cycles per access. Legal range 1..15.

Ports:
- clk  in  1  clock. All state changes on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  request valid; sampled only in IDLE.
- write_enable  in  1  1 = write, 0 = read.
- byte_enable  in  1  1 = byte access, 0 = word access.
- byte_select  in  1  byte lane: 0 = bits[7:0], 1 = bits[15:8].
- addr  in  16  word address.
- data_in  in  16  write data. Byte writes use data_in[7:0].
- data_out  out  16  read data, registered.
- mem_wait  out  1  core must hold its request while high.
- sram_addr  out  ADDR_W  SRAM address, registered.
- sram_dq_out  out  16  SRAM write data, registered.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  16  SRAM read data.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- sram_ub_n  out  1  upper-byte strobe, active-low.
- sram_lb_n  out  1  lower-byte strobe, active-low.

Behaviour:
- Reset (rst_n=0 at posedge), taking effect at that edge:
  - state=IDLE, data_out=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0.
  - ce_n, oe_n, we_n, ub_n, lb_n all =1.
  - Wait counter =0.
  - Reset mid-access aborts the access; strobes are inactive from the next cycle and data_out is cleared.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If en=1, latch addr, write_enable, byte_enable, byte_select and data_in into request registers.
  - Drive sram_addr; go to SETUP.
  - If en=0, stay in IDLE.
- SETUP (1 cycle):
  - ce_n=0; ub_n/lb_n per lane rules; oe_n=1, we_n=1.
  - Writes: sram_dq_oe=1 and sram_dq_out valid.
  - Load counter with WAIT_STATES-1; go to ACCESS.
- ACCESS (WAIT_STATES cycles):
  - ce_n=0; reads drive oe_n=0, writes drive we_n=0.
  - Counter decrements each cycle; when counter=0, go to DONE.
  - Reads: on that same edge, capture sram_dq_in into data_out per the lane rules.
- DONE (1 cycle):
  - we_n=1, oe_n=1, ce_n=1.
  - Writes keep sram_dq_oe=1 and hold data for one cycle.
  - Always go to IDLE; en is ignored in DONE.
- mem_wait (combinational) = (IDLE & en) | SETUP | ACCESS.
  - Low in DONE and in IDLE when en=0.
- Latency: request accepted at cycle 0 (IDLE & en). DONE is cycle WAIT_STATES+2, where data_out is valid and mem_wait=0.
  - The earliest next acceptance is cycle WAIT_STATES+3, so back-to-back requests are one access every WAIT_STATES+3 cycles.
- Lane rules:
  - Word access: ub_n=lb_n=0. Write drives sram_dq_out=data_in; read gives data_out=sram_dq_in.
  - Byte access: only the selected strobe is 0. Write drives sram_dq_out={data_in[7:0],data_in[7:0]}. Read gives data_out={8'h00, selected byte of sram_dq_in}.
- data_out changes only at read completion. Writes leave data_out unchanged.
- sram_dq_oe=0 in IDLE and during all read states, so there is never bus contention.
- Request inputs that change after acceptance have no effect on the access in flight.
- addr bits above ADDR_W-1 are ignored, so addresses alias modulo 2^ADDR_W.
- The request registers, not the live inputs, drive all SRAM outputs from SETUP through DONE.

Test Plan:
- Word write addr=16'h0010, data_in=16'hBEEF, WAIT_STATES=2 -> we_n low exactly cycles 2-3, sram_dq_out=BEEF, ub_n=lb_n=0; mem_wait high cycles 0-3, low at cycle 4.
- Word read of 16'h0010 with SRAM model returning BEEF -> oe_n low cycles 2-3, data_out=16'hBEEF at cycle 4 with mem_wait=0; data_out unchanged by a following write.
- Byte write data_in=16'h1234, byte_select=1 to a location holding 16'hBEEF -> only ub_n=0, sram_dq_out=16'h3434, location becomes 16'h34EF. Byte read byte_select=0 -> data_out=16'h00EF.
- en held high continuously, alternating addresses 0 and 1 -> an acceptance every WAIT_STATES+3 cycles; no strobe asserted in IDLE or DONE; sram_dq_oe never 1 during a read.
- rst_n pulled low in the second ACCESS cycle of a write -> next cycle all strobes=1, sram_dq_oe=0, data_out=0, state IDLE; a subsequent read completes normally.
- WAIT_STATES=1 and ADDR_W=8, read at addr=16'h0105 -> sram_addr=8'h05, DONE at cycle 3.
